// File: rtl/climate_pkg.sv
// Shared types and helpers for the multi-zone climate controller.
// Zone state encoding, 7-segment decode (active-low gfedcba) and '-' glyph.
package climate_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_CRIT  = 2'd2,
        ST_FAULT = 2'd3
    } zone_state_e;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] CODE_DASH = 4'hF;

    // Value -> active-low gfedcba. 4'hF renders '-', A..E blank.
    function automatic logic [6:0] seg7_decode(input logic [3:0] v);
        logic [6:0] s;
        s = SEG_BLANK;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            4'hF:    s = SEG_DASH;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/climate_zone_fsm.sv
// One climate zone: OFF/ON/CRIT/FAULT state, motor watchdog, Moore outputs.
// Ports: clk_i, rst_ni (sync, active-low), temp_i, motor_i, pres_i, ack_i,
//        state_o, fan_o, alarm_o.
module climate_zone_fsm
    import climate_pkg::*;
#(
    parameter int TEMP_W    = 5,
    parameter int T_ON      = 22,
    parameter int T_OFF     = 19,
    parameter int T_CRIT    = 28,
    parameter int MOTOR_TMO = 1000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [TEMP_W-1:0] temp_i,
    input  logic              motor_i,
    input  logic              pres_i,
    input  logic              ack_i,
    output zone_state_e       state_o,
    output logic              fan_o,
    output logic              alarm_o
);

    localparam int TW = $clog2(MOTOR_TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MOTOR_TMO - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(MOTOR_TMO);
    localparam logic [TEMP_W-1:0] TH_ON   = TEMP_W'(T_ON);
    localparam logic [TEMP_W-1:0] TH_OFF  = TEMP_W'(T_OFF);
    localparam logic [TEMP_W-1:0] TH_CRIT = TEMP_W'(T_CRIT);

    zone_state_e   state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          running;
    logic          expire;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_OFF;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        running = (state_q == ST_ON) || (state_q == ST_CRIT);
        // Saturating compare: a zone held in CRIT by heat keeps counting,
        // and must still trip once it cools with the motor still dead.
        expire  = running && !motor_i && (tmr_q >= TMO_LAST);

        tmr_d = '0;
        if (running && !motor_i) begin
            tmr_d = (tmr_q == TMO_MAX) ? tmr_q : tmr_q + TW'(1);
        end

        state_d = state_q;
        if (state_q == ST_FAULT) begin
            // Only an ack leaves FAULT; temperature is ignored here.
            state_d = ack_i ? ST_OFF : ST_FAULT;
        end else if (temp_i >= TH_CRIT) begin
            state_d = ST_CRIT;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    if (pres_i && temp_i >= TH_ON) state_d = ST_ON;
                end
                ST_ON: begin
                    if (expire) begin
                        state_d = ST_FAULT;
                    end else if (!pres_i || temp_i <= TH_OFF) begin
                        state_d = ST_OFF;
                    end
                end
                ST_CRIT: begin
                    if (expire) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = (temp_i > TH_OFF) ? ST_ON : ST_OFF;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
            endcase
        end
    end

    assign state_o = state_q;
    assign fan_o   = running;
    assign alarm_o = (state_q == ST_CRIT) || (state_q == ST_FAULT);

endmodule

// File: rtl/climate_ctrl_multi.sv
// Multi-zone fan/alarm controller with a shared 4-digit 7-segment scanner.
// Ports: CLK, Reset (sync, active-low), Temperatura, Motor, Presencia,
//        AlarmAck, ZonaSel, ContEnable -> Ventilador, Alarma, AlarmaGlobal,
//        displayCA (active-low gfedcba), displayAN (active-low, digit0=bit0).
module climate_ctrl_multi
    import climate_pkg::*;
#(
    parameter int N_ZONES   = 4,
    parameter int TEMP_W    = 5,
    parameter int T_ON      = 22,
    parameter int T_OFF     = 19,
    parameter int T_CRIT    = 28,
    parameter int MOTOR_TMO = 1000,
    parameter int SCAN_DIV  = 50000
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [N_ZONES*TEMP_W-1:0] Temperatura,
    input  logic [N_ZONES-1:0]        Motor,
    input  logic [N_ZONES-1:0]        Presencia,
    input  logic [N_ZONES-1:0]        AlarmAck,
    input  logic [2:0]                ZonaSel,
    input  logic                      ContEnable,
    output logic [N_ZONES-1:0]        Ventilador,
    output logic [N_ZONES-1:0]        Alarma,
    output logic                      AlarmaGlobal,
    output logic [6:0]                displayCA,
    output logic [3:0]                displayAN
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    zone_state_e zst [N_ZONES];

    for (genvar g = 0; g < N_ZONES; g++) begin : g_zone
        climate_zone_fsm #(
            .TEMP_W    (TEMP_W),
            .T_ON      (T_ON),
            .T_OFF     (T_OFF),
            .T_CRIT    (T_CRIT),
            .MOTOR_TMO (MOTOR_TMO)
        ) u_zone (
            .clk_i   (CLK),
            .rst_ni  (Reset),
            .temp_i  (Temperatura[g*TEMP_W +: TEMP_W]),
            .motor_i (Motor[g]),
            .pres_i  (Presencia[g]),
            .ack_i   (AlarmAck[g]),
            .state_o (zst[g]),
            .fan_o   (Ventilador[g]),
            .alarm_o (Alarma[g])
        );
    end

    assign AlarmaGlobal = |Alarma;

    logic [PW-1:0]     presc_q, presc_d;
    logic [1:0]        dig_q, dig_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        ca_q, ca_d;
    logic [TEMP_W-1:0] sel_t;
    zone_state_e       sel_st;
    logic              sel_ok;
    logic [5:0]        t6;
    logic [3:0]        tens;
    logic [3:0]        units;
    logic [3:0]        dval;

    // Pick the selected zone; out-of-range selection leaves sel_ok low.
    always_comb begin
        sel_t  = '0;
        sel_st = ST_OFF;
        sel_ok = 1'b0;
        for (int k = 0; k < N_ZONES; k++) begin
            if (ZonaSel == 3'(k)) begin
                sel_t  = Temperatura[k*TEMP_W +: TEMP_W];
                sel_st = zst[k];
                sel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        t6    = 6'(sel_t);
        tens  = 4'(t6 / 6'd10);
        units = 4'(t6 % 6'd10);

        dval = CODE_DASH;
        if (sel_ok) begin
            case (dig_q)
                2'd0:    dval = {2'b00, sel_st};
                2'd1:    dval = units;
                2'd2:    dval = tens;
                default: dval = {1'b0, ZonaSel};
            endcase
        end

        an_d = ~(4'b0001 << dig_q);
        ca_d = seg7_decode(dval);

        presc_d = presc_q;
        dig_d   = dig_q;
        if (ContEnable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                dig_d   = dig_q + 2'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Anode and cathode share one register stage so they switch together.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            presc_q <= '0;
            dig_q   <= '0;
            an_q    <= 4'b1111;
            ca_q    <= 7'b1111111;
        end else begin
            presc_q <= presc_d;
            dig_q   <= dig_d;
            an_q    <= an_d;
            ca_q    <= ca_d;
        end
    end

    assign displayAN = an_q;
    assign displayCA = ca_q;

endmodule

// File: tb/tb_climate_ctrl_multi.sv
// Scoreboard bench for climate_ctrl_multi (4 zones, MOTOR_TMO=8, SCAN_DIV=4).
// Expected outputs come from a behavioural model stepped alongside stimulus.
module tb_climate_ctrl_multi;

    localparam int NZ  = 4;
    localparam int TW  = 5;
    localparam int TMO = 8;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NZ*TW-1:0] temp_bus;
    logic [NZ-1:0] mot, pres, ack;
    logic [2:0]    zsel;
    logic          cen;
    logic [NZ-1:0] vent, alarm;
    logic          glob;
    logic [6:0]    ca;
    logic [3:0]    an;

    always #5 clk = ~clk;

    climate_ctrl_multi #(
        .N_ZONES   (NZ),
        .TEMP_W    (TW),
        .T_ON      (22),
        .T_OFF     (19),
        .T_CRIT    (28),
        .MOTOR_TMO (TMO),
        .SCAN_DIV  (DIV)
    ) dut (
        .CLK          (clk),
        .Reset        (rst_n),
        .Temperatura  (temp_bus),
        .Motor        (mot),
        .Presencia    (pres),
        .AlarmAck     (ack),
        .ZonaSel      (zsel),
        .ContEnable   (cen),
        .Ventilador   (vent),
        .Alarma       (alarm),
        .AlarmaGlobal (glob),
        .displayCA    (ca),
        .displayAN    (an)
    );

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   t[NZ];

    int         m_st[NZ];
    int         m_tm[NZ];
    int         m_presc;
    int         m_dig;
    logic [3:0] m_an;
    logic [6:0] m_ca;

    logic [6:0] seg_tb [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int nst;
        int v;
        logic run, expd;
        if (!rst_n) begin
            for (int k = 0; k < NZ; k++) begin
                m_st[k] = 0;
                m_tm[k] = 0;
            end
            m_presc = 0;
            m_dig   = 0;
            m_an    = 4'b1111;
            m_ca    = 7'b1111111;
        end else begin
            m_an = ~(4'b0001 << m_dig);
            if (zsel >= 3'(NZ)) begin
                m_ca = 7'b0111111;
            end else begin
                case (m_dig)
                    0:       v = m_st[zsel];
                    1:       v = t[zsel] % 10;
                    2:       v = t[zsel] / 10;
                    default: v = int'(zsel);
                endcase
                m_ca = seg_tb[v];
            end
            if (cen) begin
                if (m_presc == DIV - 1) begin
                    m_presc = 0;
                    m_dig   = (m_dig + 1) % 4;
                end else begin
                    m_presc++;
                end
            end
            for (int k = 0; k < NZ; k++) begin
                run  = (m_st[k] == 1) || (m_st[k] == 2);
                expd = run && !mot[k] && (m_tm[k] >= TMO - 1);
                nst  = m_st[k];
                if (m_st[k] == 3) nst = ack[k] ? 0 : 3;
                else if (t[k] >= 28) nst = 2;
                else if (m_st[k] == 0) nst = (pres[k] && t[k] >= 22) ? 1 : 0;
                else if (m_st[k] == 1) begin
                    if (expd) nst = 3;
                    else if (!pres[k] || t[k] <= 19) nst = 0;
                end else begin
                    if (expd) nst = 3;
                    else nst = (t[k] > 19) ? 1 : 0;
                end
                m_tm[k] = (run && !mot[k]) ? m_tm[k] + 1 : 0;
                m_st[k] = nst;
            end
        end
    endtask

    task automatic cyc();
        logic [NZ-1:0] ev, ea;
        exp_t e;
        logic [7:0] obs;
        for (int k = 0; k < NZ; k++) temp_bus[k*TW +: TW] = TW'(t[k]);
        model_step();
        for (int k = 0; k < NZ; k++) begin
            ev[k] = (m_st[k] == 1) || (m_st[k] == 2);
            ea[k] = (m_st[k] == 2) || (m_st[k] == 3);
        end
        sb.push_back('{"vent", 0, 8'(ev)});
        sb.push_back('{"alarm", 1, 8'(ea)});
        sb.push_back('{"glob", 2, 8'(|ea)});
        sb.push_back('{"an", 3, 8'(m_an)});
        sb.push_back('{"ca", 4, 8'(m_ca)});
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       obs = 8'(vent);
                1:       obs = 8'(alarm);
                2:       obs = 8'(glob);
                3:       obs = 8'(an);
                default: obs = 8'(ca);
            endcase
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NZ; k++) t[k] = 15;
        mot  = '1;
        pres = '0;
        ack  = '0;
        zsel = 3'd0;
        cen  = 1'b1;
        temp_bus = '0;
        run(2);
        chk("rst_vent", 8'(vent), 8'h00);
        chk("rst_an", 8'(an), 8'h0F);
        rst_n = 1'b1;

        // Zone 0 hysteresis
        pres[0] = 1'b1;
        t[0] = 18; cyc();
        t[0] = 22; cyc();
        chk("z0_on", 8'(vent[0]), 8'd1);
        t[0] = 20; run(2);
        chk("z0_band", 8'(vent[0]), 8'd1);
        t[0] = 19; cyc();
        chk("z0_off", 8'(vent[0]), 8'd0);

        // Zone 1 motor timeout
        pres[1] = 1'b1; t[1] = 23; mot[1] = 1'b0;
        cyc();
        run(TMO - 1);
        chk("z1_pre_tmo", 8'(vent[1]), 8'd1);
        cyc();
        chk("z1_fault_v", 8'(vent[1]), 8'd0);
        chk("z1_fault_a", 8'(alarm[1]), 8'd1);
        t[1] = 30; run(2);
        chk("z1_hot_fault", 8'({vent[1], alarm[1]}), 8'b01);
        t[1] = 15; ack[1] = 1'b1; cyc();
        ack[1] = 1'b0;
        chk("z1_ack", 8'(alarm[1]), 8'd0);
        mot[1] = 1'b1; pres[1] = 1'b0;

        // Zone 2 over-temperature
        t[2] = 28; cyc();
        chk("z2_crit", 8'({vent[2], alarm[2], glob}), 8'b111);
        t[2] = 21; cyc();
        chk("z2_crit_on", 8'({vent[2], alarm[2]}), 8'b10);
        cyc();
        chk("z2_nopres", 8'(vent[2]), 8'd0);
        pres[2] = 1'b1; t[2] = 28; cyc();
        t[2] = 20; cyc();
        chk("z2_band_on", 8'({vent[2], alarm[2]}), 8'b10);
        t[2] = 17; cyc();

        // Zone 3 into FAULT, then zone 0 and 3 cross T_ON together
        pres[3] = 1'b1; t[3] = 25; mot[3] = 1'b0;
        run(TMO + 1);
        t[0] = 22; t[3] = 22; cyc();
        chk("sim_z0", 8'(vent[0]), 8'd1);
        chk("sim_z3", 8'({vent[3], alarm[3]}), 8'b01);

        // Reset with zones in FAULT and CRIT
        t[2] = 29; cyc();
        chk("pre_rst_alarm", 8'(alarm[3:2]), 8'b11);
        rst_n = 1'b0; cyc();
        chk("mid_rst_out", 8'({vent, alarm, glob}), 8'h00);
        chk("mid_rst_disp", 8'({an, ca[3:0]}), 8'hFF);
        for (int k = 0; k < NZ; k++) t[k] = 15;
        pres = '0; mot = '1;

        // Display scanning on zone 1 at 25
        pres[1] = 1'b1; t[1] = 25; zsel = 3'd1; cen = 1'b1;
        rst_n = 1'b1;
        cyc();
        chk("disp_first_an", 8'(an), 8'h0E);
        run(5);
        chk("disp_d1", 8'({an, 1'b0, ca[6:4]}), 8'hD1);
        chk("disp_d1_ca", 8'(ca), 8'h12);
        run(4);
        chk("disp_d2_an", 8'(an), 8'h0B);
        chk("disp_d2_ca", 8'(ca), 8'h24);
        run(4);
        chk("disp_d3_an", 8'(an), 8'h07);
        chk("disp_d3_ca", 8'(ca), 8'h79);
        run(2);
        cen = 1'b0; run(6);
        chk("disp_freeze", 8'(an), 8'h0E);
        zsel = 3'd7; cyc();
        chk("disp_dash", 8'(ca), 8'h3F);
        cen = 1'b1; run(6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
